// File: rtl/overlay_out_stream.sv
// Output stage of the overlay: buffers the backpressure-free sample stream in a FWFT FIFO
// and re-emits it as an AXI4-Stream master with tlast framing. Optional scaling: OVERLAY_OUT_SCALE_EN.
module overlay_out_stream #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int FRAME_LEN  = 8,
    parameter int SHIFT      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          din_v,
    input  logic [2*DATA_W-1:0]           din,
    output logic [2*DATA_W-1:0]           m_tdata,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic                          m_tlast,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PW    = AW + 1;
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    if (SHIFT < 1 || SHIFT >= DATA_W) begin : g_bad_shift
        $error("overlay_out_stream: SHIFT must be in 1..DATA_W-1");
    end

    logic [2*DATA_W-1:0] mem [FIFO_DEPTH];
    logic [2*DATA_W-1:0] din_w;
    logic [2*DATA_W-1:0] head_nxt;
    logic [PW-1:0]       wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [CNT_W-1:0]    out_cnt;
    logic                full, push, pop;

`ifdef OVERLAY_OUT_SCALE_EN
    localparam logic [DATA_W:0] ROUND_ADD = (DATA_W+1)'(1) << (SHIFT - 1);

    // Round-half-up in DATA_W+1 bits; after the shift the result always fits DATA_W.
    function automatic logic [DATA_W-1:0] scale_half(input logic [DATA_W-1:0] x);
        logic signed [DATA_W:0] sum;
        sum = $signed({x[DATA_W-1], x} + ROUND_ADD);
        return DATA_W'(sum >>> SHIFT);
    endfunction

    assign din_w = {scale_half(din[2*DATA_W-1:DATA_W]), scale_half(din[DATA_W-1:0])};
`else
    assign din_w = din;
`endif

    assign fill_level = wr_ptr - rd_ptr;
    assign full       = (fill_level == PW'(FIFO_DEPTH));
    assign m_tvalid   = (wr_ptr != rd_ptr);
    assign m_tlast    = m_tvalid && (out_cnt == LAST_CNT);

    // Fullness is judged before any pop of the same cycle, so a pop never frees a slot early.
    assign push       = din_v && !full;
    assign pop        = m_tvalid && m_tready;
    assign wr_ptr_nxt = push ? wr_ptr + PW'(1) : wr_ptr;
    assign rd_ptr_nxt = pop  ? rd_ptr + PW'(1) : rd_ptr;

    // m_tdata is a register mirroring the next head, so it can reset to 0 and hold when empty.
    // The entry being written this cycle is not yet in mem, so it is forwarded from din_w.
    always_comb begin
        head_nxt = m_tdata;
        if (wr_ptr_nxt != rd_ptr_nxt) begin
            if (push && (rd_ptr_nxt == wr_ptr))
                head_nxt = din_w;
            else
                head_nxt = mem[rd_ptr_nxt[AW-1:0]];
        end
    end

    // NOTE: the storage array has no reset; pointers define validity, and leaving it
    // unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[wr_ptr[AW-1:0]] <= din_w;
    end

    // NOTE: all state updates use non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            m_tdata  <= '0;
            out_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            m_tdata <= head_nxt;
            if (din_v && full)
                overflow <= 1'b1;
            if (pop)
                out_cnt <= (out_cnt == LAST_CNT) ? '0 : out_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_overlay_out_stream.sv
// Directed self-checking bench for overlay_out_stream: ordering, backpressure, overflow,
// framing across reset, and the optional OVERLAY_OUT_SCALE_EN scaling.
module tb_overlay_out_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_v = 1'b0;
    logic [31:0] din = '0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b0;
    logic        m_tlast;
    logic        overflow;
    logic [4:0]  fill_level;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          hs_count = 0;
    int          exp_cnt  = 0;
    logic [31:0] exp_q[$];

    overlay_out_stream #(
        .DATA_W(16), .FIFO_DEPTH(16), .FRAME_LEN(8), .SHIFT(4)
    ) dut (
        .clk(clk), .rst(rst), .din_v(din_v), .din(din),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .overflow(overflow), .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboards any handshake about to occur at the coming edge, then advances one cycle.
    task automatic tick();
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                check("hs_unexpected", 64'(m_tdata), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("hs_data", 64'(m_tdata), 64'(exp_q[0]));
                check("hs_last", 64'(m_tlast), 64'(exp_cnt == 7));
                void'(exp_q.pop_front());
            end
            exp_cnt = (exp_cnt + 1) % 8;
            hs_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; din_v = 1'b0; m_tready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
    endtask

    task automatic write(input logic [31:0] d, input logic [31:0] e, input logic accepted);
        din_v = 1'b1; din = d;
        if (accepted) exp_q.push_back(e);
        tick();
        din_v = 1'b0;
    endtask

    task automatic drain(input string tag);
        din_v = 1'b0; m_tready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick();
        check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_valid"}, 64'(m_tvalid), 64'd0);
        check({tag, "_fill"}, 64'(fill_level), 64'd0);
    endtask

    initial begin
        logic [31:0] s;
        logic [31:0] e0, e1;
        int          hs0;

        // Reset state
        do_reset();
        check("rst_valid", 64'(m_tvalid), 64'd0);
        check("rst_data", 64'(m_tdata), 64'd0);
        check("rst_last", 64'(m_tlast), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_fill", 64'(fill_level), 64'd0);

        // T1: 8 back-to-back samples streaming through with m_tready=1
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s = {16'(i + 1), 16'(i + 2)};
            din_v = 1'b1; din = s;
            exp_q.push_back(s);
            tick();
            check("t1_valid", 64'(m_tvalid), 64'd1);
            check("t1_data", 64'(m_tdata), 64'(s));
            check("t1_last", 64'(m_tlast), 64'(i == 7));
        end
        din_v = 1'b0;
        tick();
        check("t1_empty_valid", 64'(m_tvalid), 64'd0);
        check("t1_hold_data", 64'(m_tdata), 64'h0008_0009);
        check("t1_left", 64'(exp_q.size()), 64'd0);

        // T2: fill to 16 with no readiness, drop a 17th, then drain
        do_reset();
        for (int i = 0; i < 16; i++) begin
            s = {16'(16'h0100 + i), 16'(16'h0200 + i)};
            write(s, s, 1'b1);
        end
        check("t2_fill16", 64'(fill_level), 64'd16);
        check("t2_no_ovf", 64'(overflow), 64'd0);
        write(32'hDEAD_BEEF, 32'h0, 1'b0);
        check("t2_ovf", 64'(overflow), 64'd1);
        check("t2_fill_still16", 64'(fill_level), 64'd16);
        hs0 = hs_count;
        drain("t2_drain");
        check("t2_hs_count", 64'(hs_count - hs0), 64'd16);
        check("t2_ovf_sticky", 64'(overflow), 64'd1);

        // T3: four entries, stalled readiness pattern
        do_reset();
        check("t3_ovf_cleared", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            s = {16'hA000 + 16'(i), 16'hB000 + 16'(i)};
            write(s, s, 1'b1);
        end
        check("t3_fill4", 64'(fill_level), 64'd4);
        hs0 = hs_count;
        begin
            logic [6:0] pat;
            pat = 7'b1101001; // applied LSB first: 1,0,0,1,0,1,1
            for (int i = 0; i < 7; i++) begin
                m_tready = pat[i];
                tick();
                if (exp_q.size() > 0) begin
                    check("t3_head_data", 64'(m_tdata), 64'(exp_q[0]));
                    check("t3_head_last", 64'(m_tlast), 64'd0);
                end
            end
        end
        check("t3_hs_count", 64'(hs_count - hs0), 64'd4);
        check("t3_empty", 64'(m_tvalid), 64'd0);

        // T4: push at full with concurrent pop is dropped; push+pop at fill 5 holds fill
        do_reset();
        for (int i = 0; i < 16; i++) begin
            s = {16'hC000 + 16'(i), 16'hD000 + 16'(i)};
            write(s, s, 1'b1);
        end
        m_tready = 1'b1;
        write(32'h1234_5678, 32'h0, 1'b0);
        check("t4_ovf", 64'(overflow), 64'd1);
        check("t4_fill15", 64'(fill_level), 64'd15);
        for (int i = 0; i < 10; i++) tick();
        check("t4_fill5", 64'(fill_level), 64'd5);
        write(32'h5555_AAAA, 32'h5555_AAAA, 1'b1);
        check("t4_fill_hold5", 64'(fill_level), 64'd5);
        drain("t4_drain");

        // T5: reset mid-frame restarts framing
        do_reset();
        for (int i = 0; i < 5; i++) begin
            s = {16'hE000 + 16'(i), 16'hF000 + 16'(i)};
            write(s, s, 1'b1);
        end
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("t5_pre_fill", 64'(fill_level), 64'd2);
        m_tready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_cnt = 0;
        check("t5_rst_valid", 64'(m_tvalid), 64'd0);
        check("t5_rst_data", 64'(m_tdata), 64'd0);
        check("t5_rst_last", 64'(m_tlast), 64'd0);
        check("t5_rst_fill", 64'(fill_level), 64'd0);
        m_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s = {16'h0300 + 16'(i), 16'h0400 + 16'(i)};
            din_v = 1'b1; din = s;
            exp_q.push_back(s);
            tick();
            check("t5_last", 64'(m_tlast), 64'(i == 7));
        end
        drain("t5_drain");

        // T6: scaling (or pass-through when the macro is undefined)
        do_reset();
`ifdef OVERLAY_OUT_SCALE_EN
        e0 = 32'h0002_FFFF;
        e1 = 32'h0800_F800;
`else
        e0 = 32'h0018_FFE8;
        e1 = 32'h7FFF_8000;
`endif
        write(32'h0018_FFE8, e0, 1'b1);
        check("t6_head0", 64'(m_tdata), 64'(e0));
        write(32'h7FFF_8000, e1, 1'b1);
        drain("t6_drain");
        check("t6_hold_last", 64'(m_tdata), 64'(e1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
